// File: rtl/demux_1_8_deser.sv
// Serial-to-parallel deserializer: steers each valid serial bit into slot k of an
// N_OUT-bit assembly register and presents completed frames through a valid/ready port.
module demux_1_8_deser #(
  parameter int N_OUT = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [N_OUT-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] slot,
  output logic             overrun,
  output logic             sync_err
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_OUT - 1);

  logic [N_OUT-1:0] asm_q, asm_d;
  logic [N_OUT-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic             overrun_q, overrun_d;
  logic             sync_err_q, sync_err_d;

  logic [SEL_W-1:0] wptr;
  logic             consume;
  logic             complete;

  // A qualified sync forces the write back to slot 0, abandoning any partial frame.
  assign wptr     = sync ? '0 : slot_q;
  assign consume  = out_valid_q & out_ready;
  assign complete = din_valid & (wptr == LAST_SLOT);

  always_comb begin
    asm_d       = asm_q;
    slot_d      = slot_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    sync_err_d  = 1'b0;

    if (consume) begin
      out_valid_d = 1'b0;
    end

    if (din_valid) begin
      asm_d[wptr] = din;
      slot_d      = wptr + SEL_W'(1);
      sync_err_d  = sync & (slot_q != '0);
    end

    // The output slot is free if empty or being drained on this same edge.
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_d       = asm_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      slot_q      <= '0;
      overrun_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      slot_q      <= slot_d;
      overrun_q   <= overrun_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign slot      = slot_q;
  assign overrun   = overrun_q;
  assign sync_err  = sync_err_q;

endmodule

// File: doc/demux_1_8_deser.md
Name: demux_1_8_deser

Overview:
- Receive-side counterpart to the team's 8-to-1 mux when that mux is driven by a rotating select to serialize a byte.
- Takes the serial bit stream plus valid/sync qualifiers and steers each bit into slot k of an 8-entry assembly register, with k = 0..7.
- Presents each completed frame as a registered 8-bit word with a valid/ready handshake.
- Bit-to-slot mapping is the inverse of the mux: select value k on the transmit side corresponds to out[k] here.

Parameters:
- N_OUT, 8, number of output slots (frame length in bits); power of two, 2..256.
- SEL_W, 3, slot pointer width; must equal log2(N_OUT).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- din  input  1  serial data bit
- din_valid  input  1  din is sampled this cycle
- sync  input  1  frame start; qualified by din_valid, marks the current din as slot 0
- out  output  N_OUT  completed frame; out[k] = bit received in slot k
- out_valid  output  1  out holds an unconsumed frame
- out_ready  input  1  consumer accepts out this cycle when out_valid=1
- slot  output  SEL_W  slot index the next valid bit will be written to
- overrun  output  1  one-cycle pulse: completed frame dropped because output was full
- sync_err  output  1  one-cycle pulse: sync arrived while slot != 0 (partial frame discarded)

Behaviour:
- Reset (async assert, sync deassert w.r.t. clk): out=0, out_valid=0, slot=0, overrun=0, sync_err=0, assembly register=0.
- Reset mid-frame discards the partial frame and any pending out word.
- Bit write: on a clk edge with din_valid=1, asm[wptr] <= din, where wptr = 0 if sync=1, else slot.
- Slot advance: after a write, slot <= wptr+1 modulo N_OUT, so 7 wraps to 0.
- din_valid=0: no state change in asm or slot, and sync is ignored.
- Frame completion: a write with wptr = N_OUT-1 completes the frame. The same edge transfers the assembled word, including the bit just written, into out.
- Completion latency: out_valid rises on the edge that samples slot-7's bit, i.e. it is visible the cycle after the last valid bit.
- Handshake: consumption occurs on an edge where out_valid=1 and out_ready=1; it clears out_valid unless a new frame completes on the same edge.
- out holds stable while out_valid=1 and not consumed. out retains its last value after consumption; the data is don't-care when out_valid=0.
- Completion while out_valid=0: load out, set out_valid=1.
- Completion while out_valid=1 and out_ready=1 (simultaneous consume + complete): load the new frame, keep out_valid=1, no overrun.
- Completion while out_valid=1 and out_ready=0: new frame dropped; out and out_valid unchanged; overrun=1 for exactly one cycle.
- sync with din_valid=1 and slot != 0: sync_err=1 for one cycle, the partial frame is abandoned, and the bit is written to slot 0.
- sync with din_valid=1 and slot == 0: normal, no error.
- sync on consecutive valid bits: each restarts at slot 0, so slot ends at 1. sync_err fires only if slot was nonzero.
- Assembly register bits not yet written in a frame keep stale values; completion always requires all N_OUT slots, so stale bits never reach out unless sync resyncs mid-frame. In that case, slots 1..N_OUT-1 are overwritten before completion anyway.
- overrun and sync_err are registered pulses, 0 otherwise. They are independent and may assert in the same cycle.
- Fully synchronous datapath; no combinational path from inputs to outputs.

Test Plan:
- Reset then 8 consecutive valid bits, LSB first, of 0xA5 with sync on the first, out_ready=1 → out=0xA5, out_valid high for 1 cycle, slot returns to 0, no pulses.
- Same 0xA5 stream with din_valid deasserted for 3 cycles between bits 3 and 4 → slot holds at 4 during gaps; out=0xA5 one cycle after the 8th valid bit.
- Two back-to-back frames 0x3C then 0xC3 with out_ready=0 → out=0x3C stays valid; overrun pulses once when the 2nd frame completes. Raising out_ready then clears out_valid.
- Frame 0x0F completing on the same edge as out_ready consuming the prior 0xF0 → out=0x0F, out_valid stays 1, overrun=0.
- Sync asserted on the 5th valid bit of a frame → sync_err pulses once; the next 8 bits starting there assemble correctly (send 0x81 → out=0x81).
- Assert rst asynchronously mid-frame (slot=5) and while out_valid=1 → immediate out_valid=0, slot=0, out=0. A fresh 0x5A frame after release is received intact.
